// File: rtl/ram_seq_master_if.sv
// Initiator-side bundle for ram_seq_master: command handshake, DUMP stream and RAM strobes.
// The RAM_SEQ_VERIFY_EN build adds the expected-data check signals.
interface ram_seq_master_if #(
    parameter int N = 4,
    parameter int M = 4
);
    logic [1:0]   cmd_i;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [N-1:0] base_i;
    logic [N:0]   count_i;
    logic [M-1:0] seed_i;
    logic [M-1:0] step_i;
    logic [N-1:0] addr_o;
    logic         wren_o;
    logic [M-1:0] dato_write_o;
    logic         rden_o;
    logic [M-1:0] dato_read_i;
    logic [M-1:0] rd_data_o;
    logic         rd_valid_o;
    logic         rd_ready_i;
    logic         busy_o;
    logic         done_o;
`ifdef RAM_SEQ_VERIFY_EN
    logic         exp_check_i;
    logic [N:0]   err_cnt_o;
    logic         err_o;

    modport master (
        input  cmd_i, cmd_valid_i, base_i, count_i, seed_i, step_i,
               dato_read_i, rd_ready_i, exp_check_i,
        output cmd_ready_o, addr_o, wren_o, dato_write_o, rden_o,
               rd_data_o, rd_valid_o, busy_o, done_o, err_cnt_o, err_o
    );
    modport slave (
        output cmd_i, cmd_valid_i, base_i, count_i, seed_i, step_i,
               dato_read_i, rd_ready_i, exp_check_i,
        input  cmd_ready_o, addr_o, wren_o, dato_write_o, rden_o,
               rd_data_o, rd_valid_o, busy_o, done_o, err_cnt_o, err_o
    );
`else
    modport master (
        input  cmd_i, cmd_valid_i, base_i, count_i, seed_i, step_i,
               dato_read_i, rd_ready_i,
        output cmd_ready_o, addr_o, wren_o, dato_write_o, rden_o,
               rd_data_o, rd_valid_o, busy_o, done_o
    );
    modport slave (
        output cmd_i, cmd_valid_i, base_i, count_i, seed_i, step_i,
               dato_read_i, rd_ready_i,
        input  cmd_ready_o, addr_o, wren_o, dato_write_o, rden_o,
               rd_data_o, rd_valid_o, busy_o, done_o
    );
`endif
endinterface

// File: rtl/ram_seq_master.sv
// Block sequencer (FILL / DUMP / CLEAR) driving a single-port RAM with async read data.
// Optional DUMP data checker enabled by defining RAM_SEQ_VERIFY_EN.
module ram_seq_master #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    ram_seq_master_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_DUMP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t       state_r;
    logic [N:0]   k_r;
    logic [N:0]   count_r;
    logic [N-1:0] addr_r;
    logic [M-1:0] step_r;
    logic [M-1:0] dato_write_r;
    logic [M-1:0] rd_data_r;
    logic         wren_r;
    logic         rden_r;
    logic         rd_valid_r;
    logic         busy_r;
    logic         done_r;
    logic         cmd_ready_r;
    logic         last_s;
    logic         load_s;
    logic         accept_s;
`ifdef RAM_SEQ_VERIFY_EN
    logic         chk_en_r;
    logic [M-1:0] exp_r;
    logic [N:0]   err_cnt_r;
    logic         err_r;
`endif

    // Decode of the current word position and stream/command handshakes.
    always_comb begin
        last_s   = (k_r == (count_r - {{N{1'b0}}, 1'b1}));
        load_s   = !rd_valid_r || bus.rd_ready_i;
        accept_s = bus.cmd_valid_i && (bus.cmd_i != 2'b00);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            k_r          <= {(N+1){1'b0}};
            count_r      <= {(N+1){1'b0}};
            addr_r       <= {N{1'b0}};
            step_r       <= {M{1'b0}};
            dato_write_r <= {M{1'b0}};
            rd_data_r    <= {M{1'b0}};
            wren_r       <= 1'b0;
            rden_r       <= 1'b0;
            rd_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            cmd_ready_r  <= 1'b1;
`ifdef RAM_SEQ_VERIFY_EN
            chk_en_r     <= 1'b0;
            exp_r        <= {M{1'b0}};
            err_cnt_r    <= {(N+1){1'b0}};
            err_r        <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_r      <= bus.base_i;
                        count_r     <= bus.count_i;
                        k_r         <= {(N+1){1'b0}};
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        // CLEAR reuses the FILL datapath with zero seed and zero step.
                        step_r       <= (bus.cmd_i == 2'b11) ? {M{1'b0}} : bus.step_i;
                        dato_write_r <= (bus.cmd_i == 2'b01) ? bus.seed_i : {M{1'b0}};
`ifdef RAM_SEQ_VERIFY_EN
                        if (bus.cmd_i == 2'b10) begin
                            chk_en_r  <= bus.exp_check_i;
                            exp_r     <= bus.seed_i;
                            err_cnt_r <= {(N+1){1'b0}};
                            err_r     <= 1'b0;
                        end else begin
                            chk_en_r  <= 1'b0;
                        end
`endif
                        if (bus.count_i == {(N+1){1'b0}}) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else if (bus.cmd_i == 2'b10) begin
                            state_r <= ST_DUMP;
                            rden_r  <= 1'b1;
                        end else begin
                            state_r <= ST_FILL;
                            wren_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (last_s) begin
                        wren_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        k_r          <= k_r + {{N{1'b0}}, 1'b1};
                        addr_r       <= addr_r + {{(N-1){1'b0}}, 1'b1};
                        dato_write_r <= dato_write_r + step_r;
                    end
                end
                ST_DUMP: begin
                    if (load_s) begin
                        rd_data_r  <= bus.dato_read_i;
                        rd_valid_r <= 1'b1;
`ifdef RAM_SEQ_VERIFY_EN
                        exp_r <= exp_r + step_r;
                        if (chk_en_r && (bus.dato_read_i != exp_r)) begin
                            err_cnt_r <= err_cnt_r + {{N{1'b0}}, 1'b1};
                            err_r     <= 1'b1;
                        end else begin
                            err_r     <= err_r;
                        end
`endif
                        if (last_s) begin
                            rden_r  <= 1'b0;
                            state_r <= ST_DRAIN;
                        end else begin
                            k_r    <= k_r + {{N{1'b0}}, 1'b1};
                            addr_r <= addr_r + {{(N-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_r <= ST_DUMP;
                    end
                end
                ST_DRAIN: begin
                    if (rd_valid_r && bus.rd_ready_i) begin
                        rd_valid_r <= 1'b0;
                        done_r     <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    wren_r      <= 1'b0;
                    rden_r      <= 1'b0;
                    rd_valid_r  <= 1'b0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // The write strobe is masked by reset so an abort suppresses the write of the reset cycle itself.
    assign bus.wren_o       = wren_r && !rst_i;
    assign bus.rden_o       = rden_r;
    assign bus.addr_o       = addr_r;
    assign bus.dato_write_o = dato_write_r;
    assign bus.rd_data_o    = rd_data_r;
    assign bus.rd_valid_o   = rd_valid_r;
    assign bus.busy_o       = busy_r;
    assign bus.done_o       = done_r;
    assign bus.cmd_ready_o  = cmd_ready_r;
`ifdef RAM_SEQ_VERIFY_EN
    assign bus.err_cnt_o    = err_cnt_r;
    assign bus.err_o        = err_r;
`endif
endmodule

// File: tb/tb_ram_seq_master.sv
// Directed bench for ram_seq_master: vector table of block operations plus stall/clear/reset sequences.
module tb_ram_seq_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    ram_seq_master_if #(.N(4), .M(4)) bus();
    ram_seq_master #(.N(4), .M(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: synchronous write, combinational read, zero when not enabled.
    logic [3:0] mem [16] = '{default: 4'h0};
    always @(posedge clk) if (bus.wren_o) mem[bus.addr_o] <= bus.dato_write_o;
    assign bus.dato_read_i = bus.rden_o ? mem[bus.addr_o] : 4'h0;
`ifdef RAM_SEQ_VERIFY_EN
    assign bus.exp_check_i = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  cmd;
        logic [3:0]  base;
        logic [4:0]  count;
        logic [3:0]  seed;
        logic [3:0]  step;
        logic [3:0]  rdy;
        logic [4:0]  nwr;
        logic [15:0] wa;
        logic [15:0] wd;
        logic [4:0]  nrd;
        logic [15:0] rdd;
        logic [7:0]  lat;
    } vec_t;

    logic [3:0] wa_q [$];
    logic [3:0] wd_q [$];
    int         wc_q [$];
    logic [3:0] rd_q [$];
    bit  done_seen = 1'b0;
    int  done_cyc = 0;
    int  done_cnt = 0;
    int  excl_err = 0;
    bit  prev_v = 1'b0, prev_r = 1'b0;
    logic [3:0] prev_d = 4'h0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle monitor: logs writes, accepted beats, done pulses and checks stream hold.
    always @(negedge clk) begin
        if (bus.wren_o) begin
            wa_q.push_back(bus.addr_o);
            wd_q.push_back(bus.dato_write_o);
            wc_q.push_back(cyc);
        end
        if (bus.wren_o && bus.rden_o) excl_err++;
        if (bus.rd_valid_o && bus.rd_ready_i) rd_q.push_back(bus.rd_data_o);
        if (bus.done_o) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            done_cnt++;
        end
        if (prev_v && !prev_r) begin
            chk("hold_valid", int'(bus.rd_valid_o), 1);
            chk("hold_data", int'(bus.rd_data_o), int'(prev_d));
        end
        prev_v = bus.rd_valid_o;
        prev_r = bus.rd_ready_i;
        prev_d = bus.rd_data_o;
    end

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); rd_q.delete();
        done_seen = 1'b0;
        done_cnt  = 0;
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [3:0] base, input logic [4:0] count,
                         input logic [3:0] seed, input logic [3:0] step, output int acc);
        bus.cmd_i = cmd; bus.base_i = base; bus.count_i = count;
        bus.seed_i = seed; bus.step_i = step; bus.cmd_valid_i = 1'b1;
        tick();
        acc = cyc;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i = 2'b00;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int acc;
        int j;
        logic [15:0] t;
        clear_logs();
        issue(v.cmd, v.base, v.count, v.seed, v.step, acc);
        j = 0;
        bus.rd_ready_i = v.rdy[0];
        while (!done_seen && j < 200) begin
            tick();
            j++;
            bus.rd_ready_i = v.rdy[j % 4];
        end
        if (!done_seen) begin
            chk({name, "_done_timeout"}, 0, 1);
        end else begin
            chk({name, "_latency"}, done_cyc - acc, int'(v.lat));
        end
        bus.rd_ready_i = 1'b1;
        tick(); tick();
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_ready_back"}, int'(bus.cmd_ready_o), 1);
        chk({name, "_nwr"}, wa_q.size(), int'(v.nwr));
        for (int i = 0; i < wa_q.size() && i < 4; i++) begin
            t = v.wa;
            chk({name, "_waddr"}, int'(wa_q[i]), int'(t[4*i +: 4]));
            t = v.wd;
            chk({name, "_wdata"}, int'(wd_q[i]), int'(t[4*i +: 4]));
            chk({name, "_wcyc"}, wc_q[i] - acc, i);
        end
        chk({name, "_nrd"}, rd_q.size(), int'(v.nrd));
        for (int i = 0; i < rd_q.size() && i < 4; i++) begin
            t = v.rdd;
            chk({name, "_rdata"}, int'(rd_q[i]), int'(t[4*i +: 4]));
        end
    endtask

    vec_t vec [6];
    int   acc;

    initial begin
        vec[0] = '{2'b01, 4'd2,  5'd4, 4'd3, 4'd1, 4'b1111, 5'd4, 16'h5432, 16'h6543, 5'd0, 16'h0000, 8'd4};
        vec[1] = '{2'b01, 4'd14, 5'd4, 4'd0, 4'd5, 4'b1111, 5'd4, 16'h10FE, 16'hFA50, 5'd0, 16'h0000, 8'd4};
        vec[2] = '{2'b10, 4'd2,  5'd4, 4'd0, 4'd0, 4'b1111, 5'd0, 16'h0000, 16'h0000, 5'd4, 16'h6543, 8'd5};
        vec[3] = '{2'b10, 4'd14, 5'd4, 4'd0, 4'd0, 4'b1111, 5'd0, 16'h0000, 16'h0000, 5'd4, 16'hFA50, 8'd5};
        vec[4] = '{2'b10, 4'd2,  5'd4, 4'd0, 4'd0, 4'b1001, 5'd0, 16'h0000, 16'h0000, 5'd4, 16'h6543, 8'd9};
        vec[5] = '{2'b01, 4'd7,  5'd0, 4'd9, 4'd1, 4'b1111, 5'd0, 16'h0000, 16'h0000, 5'd0, 16'h0000, 8'd0};

        bus.cmd_i = 2'b00; bus.cmd_valid_i = 1'b0; bus.base_i = 4'h0; bus.count_i = 5'd0;
        bus.seed_i = 4'h0; bus.step_i = 4'h0; bus.rd_ready_i = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_addr", int'(bus.addr_o), 0);
        chk("rst_wren", int'(bus.wren_o), 0);
        chk("rst_rden", int'(bus.rden_o), 0);
        chk("rst_wdata", int'(bus.dato_write_o), 0);
        chk("rst_rdata", int'(bus.rd_data_o), 0);
        chk("rst_rvalid", int'(bus.rd_valid_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_done", int'(bus.done_o), 0);
        chk("rst_ready", int'(bus.cmd_ready_o), 1);

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vec[i]);

        // NOP is ignored: no done pulse, stays ready.
        clear_logs();
        issue(2'b00, 4'd3, 5'd4, 4'd1, 4'd1, acc);
        tick(); tick(); tick();
        chk("nop_done", done_cnt, 0);
        chk("nop_busy", int'(bus.busy_o), 0);
        chk("nop_ready", int'(bus.cmd_ready_o), 1);

        // CLEAR over the whole RAM starting at 5 with wrap.
        clear_logs();
        issue(2'b11, 4'd5, 5'd16, 4'hF, 4'h3, acc);
        for (int j = 0; j < 40 && !done_seen; j++) tick();
        chk("clr_done_seen", int'(done_seen), 1);
        chk("clr_latency", done_cyc - acc, 16);
        chk("clr_nwr", wa_q.size(), 16);
        for (int i = 0; i < wa_q.size() && i < 16; i++) begin
            chk("clr_waddr", int'(wa_q[i]), (5 + i) % 16);
            chk("clr_wdata", int'(wd_q[i]), 0);
        end
        tick();
        for (int i = 0; i < 16; i++) chk("clr_mem", int'(mem[i]), 0);

        // Reset during the third write of an 8-word FILL.
        clear_logs();
        issue(2'b01, 4'd0, 5'd8, 4'd1, 4'd1, acc);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_wren_now", int'(bus.wren_o), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_wren", int'(bus.wren_o), 0);
        chk("abort_busy", int'(bus.busy_o), 0);
        chk("abort_ready", int'(bus.cmd_ready_o), 1);
        chk("abort_addr", int'(bus.addr_o), 0);
        tick(); tick();
        chk("abort_nwr", wa_q.size(), 2);
        chk("abort_done", done_cnt, 0);
        chk("abort_mem0", int'(mem[0]), 1);
        chk("abort_mem1", int'(mem[1]), 2);
        chk("abort_mem2", int'(mem[2]), 0);
        chk("strobe_excl", excl_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
